handshake_delay_full: RTL and testbench

//   Full registered valid/ready slice: down_valid/down_data and up_ready all driven from flops.

---
 rtl/handshake_delay_full_pkg.sv | 11 +
 rtl/handshake_delay_full_hs_beat_counter.sv | 21 ++
 rtl/handshake_delay_full.sv | 100 ++++++++++
 tb/tb_handshake_delay_full.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/handshake_delay_full_pkg.sv
// Shared types for the fully registered valid/ready slice.
package handshake_delay_full_pkg;

  // Occupancy state; the encoding doubles as the beat count held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/handshake_delay_full_hs_beat_counter.sv
// Free-running beat counter, wraps modulo 2^CNT_WIDTH.
module hs_beat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;

  // Count one per qualifying beat; overflow wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else if (inc) count_q <= count_q + CNT_WIDTH'(1);
  end

  assign count = count_q;

endmodule

// File: rtl/handshake_delay_full.sv
// Two-entry (main + skid) valid/ready slice with every output driven from a flop.
module handshake_delay_full
  import handshake_delay_full_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  up_valid,
  input  logic [WORD_WIDTH-1:0] up_data,
  output logic                  up_ready,
  output logic                  down_valid,
  output logic [WORD_WIDTH-1:0] down_data,
  input  logic                  down_ready,
  output logic [1:0]            level,
  output logic [CNT_WIDTH-1:0]  up_cnt,
  output logic [CNT_WIDTH-1:0]  down_cnt
);

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] main_q, main_d;
  logic [WORD_WIDTH-1:0] skid_q, skid_d;
  logic                  up_ready_q, down_valid_q;
  logic [1:0]            level_q;
  logic                  up_fire, dn_fire;

  assign up_fire = up_valid & up_ready_q;
  assign dn_fire = down_valid_q & down_ready;

  // Next-state and datapath steering; flush overrides whatever the FSM chose.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: if (up_fire) begin
        state_d = ST_BUSY;
        main_d  = up_data;
      end
      ST_BUSY: begin
        if (up_fire && !dn_fire) begin
          state_d = ST_FULL;
          skid_d  = up_data;
        end else if (!up_fire && dn_fire) begin
          state_d = ST_EMPTY;
        end else if (up_fire && dn_fire) begin
          main_d  = up_data;
        end
      end
      ST_FULL: if (dn_fire) begin
        state_d = ST_BUSY;
        main_d  = skid_q;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  // State, buffers and handshake outputs, all decoded from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      main_q       <= '0;
      skid_q       <= '0;
      up_ready_q   <= 1'b1;
      down_valid_q <= 1'b0;
      level_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      up_ready_q   <= (state_d != ST_FULL);
      down_valid_q <= (state_d != ST_EMPTY);
      level_q      <= state_d;
    end
  end

  assign up_ready   = up_ready_q;
  assign down_valid = down_valid_q;
  assign down_data  = main_q;
  assign level      = level_q;

  // A beat arriving in a flush cycle is dropped, so it is not counted.
  hs_beat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_up_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (up_fire & ~flush),
    .count (up_cnt)
  );

  hs_beat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_down_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (dn_fire),
    .count (down_cnt)
  );

endmodule

// File: tb/tb_handshake_delay_full.sv
// Bench for handshake_delay_full: scenario tasks plus a scoreboard monitor.
module tb_handshake_delay_full;

  logic        clk = 1'b0;
  logic        rst_n, flush, up_valid, down_ready;
  logic [7:0]  up_data;
  logic        up_ready, down_valid;
  logic [7:0]  down_data;
  logic [1:0]  level;
  logic [15:0] up_cnt, down_cnt;
  logic        up_ready4, down_valid4;
  logic [7:0]  down_data4;
  logic [1:0]  level4;
  logic [3:0]  up_cnt4, down_cnt4;

  int chk = 0;
  int pass = 0;
  logic [7:0] sb[$];

  always #10 clk = ~clk;

  handshake_delay_full #(.WORD_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .up_valid(up_valid), .up_data(up_data),
    .up_ready(up_ready), .down_valid(down_valid), .down_data(down_data),
    .down_ready(down_ready), .level(level), .up_cnt(up_cnt), .down_cnt(down_cnt));

  // Narrow-counter instance sharing the same stimulus, for wrap checks.
  handshake_delay_full #(.WORD_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .up_valid(up_valid), .up_data(up_data),
    .up_ready(up_ready4), .down_valid(down_valid4), .down_data(down_data4),
    .down_ready(down_ready), .level(level4), .up_cnt(up_cnt4), .down_cnt(down_cnt4));

  // Scoreboard monitor, sampled mid-cycle ahead of the next rising edge.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic [7:0] exp_d;
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      chk++;
      if (level !== 2'(sb.size())) $display("FAIL sb_level got %0d want %0d", level, sb.size());
      else pass++;
      chk++;
      if (down_valid !== (sb.size() != 0)) $display("FAIL sb_valid got %0b want %0b", down_valid, sb.size() != 0);
      else pass++;
      if (prev_stall) begin
        chk++;
        if (down_valid !== 1'b1 || down_data !== prev_data)
          $display("FAIL hold got v=%0b d=%02h want v=1 d=%02h", down_valid, down_data, prev_data);
        else pass++;
      end
      if (down_valid && down_ready) begin
        chk++;
        if (sb.size() == 0) $display("FAIL sb_underflow got d=%02h want none", down_data);
        else begin
          exp_d = sb.pop_front();
          if (down_data !== exp_d) $display("FAIL sb_data got %02h want %02h", down_data, exp_d);
          else pass++;
        end
      end
      if (flush) sb.delete();
      else if (up_valid && up_ready) sb.push_back(up_data);
      prev_stall = down_valid && !down_ready && !flush;
      prev_data  = down_data;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; up_valid = 1'b0; flush = 1'b0; down_ready = 1'b0; up_data = 8'h00;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; down_ready = 1'b0; up_valid = 1'b1; up_data = 8'h77;
    #35;
    chk++; if (up_ready !== 1'b1) $display("FAIL rst_up_ready got %0b want 1", up_ready); else pass++;
    chk++; if (down_valid !== 1'b0) $display("FAIL rst_down_valid got %0b want 0", down_valid); else pass++;
    chk++; if (level !== 2'd0) $display("FAIL rst_level got %0d want 0", level); else pass++;
    chk++; if (up_cnt !== 16'd0 || down_cnt !== 16'd0) $display("FAIL rst_cnt got %0d/%0d want 0/0", up_cnt, down_cnt); else pass++;
    chk++; if (down_data !== 8'h00) $display("FAIL rst_data got %02h want 00", down_data); else pass++;
    rst_n = 1'b1;
    step();
    chk++; if (down_valid !== 1'b1 || down_data !== 8'h77) $display("FAIL rst_first got v=%0b d=%02h want v=1 d=77", down_valid, down_data); else pass++;
    chk++; if (up_cnt !== 16'd1) $display("FAIL rst_first_cnt got %0d want 1", up_cnt); else pass++;
    up_valid = 1'b0; down_ready = 1'b1;
    step();
    chk++; if (down_valid !== 1'b0 || down_cnt !== 16'd1) $display("FAIL rst_drain got v=%0b c=%0d want v=0 c=1", down_valid, down_cnt); else pass++;
  endtask

  task automatic test_streaming();
    logic ready_ok;
    apply_reset();
    down_ready = 1'b1;
    ready_ok = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      up_valid = 1'b1; up_data = 8'(i);
      step();
      if (up_ready !== 1'b1) ready_ok = 1'b0;
      chk++;
      if (down_valid !== 1'b1 || down_data !== 8'(i)) $display("FAIL stream_lat got v=%0b d=%02h want v=1 d=%02h", down_valid, down_data, 8'(i));
      else pass++;
    end
    up_valid = 1'b0;
    step();
    chk++; if (ready_ok !== 1'b1) $display("FAIL stream_ready got dropped want steady 1"); else pass++;
    chk++; if (up_cnt !== 16'd16 || down_cnt !== 16'd16) $display("FAIL stream_cnt got %0d/%0d want 16/16", up_cnt, down_cnt); else pass++;
    chk++; if (level !== 2'd0) $display("FAIL stream_level got %0d want 0", level); else pass++;
  endtask

  task automatic test_backpressure();
    apply_reset();
    down_ready = 1'b0; up_valid = 1'b1; up_data = 8'hA1;
    step();
    up_data = 8'hA2;
    step();
    up_data = 8'hA3;
    step();
    chk++; if (level !== 2'd2 || up_ready !== 1'b0) $display("FAIL bp_full got l=%0d r=%0b want l=2 r=0", level, up_ready); else pass++;
    chk++; if (down_data !== 8'hA1) $display("FAIL bp_head got %02h want a1", down_data); else pass++;
    chk++; if (up_cnt !== 16'd2) $display("FAIL bp_upcnt got %0d want 2", up_cnt); else pass++;
    down_ready = 1'b1;
    step();
    chk++; if (down_data !== 8'hA2 || up_ready !== 1'b1) $display("FAIL bp_a2 got d=%02h r=%0b want d=a2 r=1", down_data, up_ready); else pass++;
    step();
    chk++; if (down_data !== 8'hA3 || level !== 2'd1) $display("FAIL bp_a3 got d=%02h l=%0d want d=a3 l=1", down_data, level); else pass++;
    up_valid = 1'b0;
    step();
    chk++; if (down_valid !== 1'b0 || up_cnt !== 16'd3 || down_cnt !== 16'd3) $display("FAIL bp_end got v=%0b %0d/%0d want v=0 3/3", down_valid, up_cnt, down_cnt); else pass++;
  endtask

  task automatic test_toggle();
    apply_reset();
    for (int c = 0; c < 200; c++) begin
      down_ready = (c % 2 == 1);
      up_valid   = 1'($urandom_range(0, 1));
      up_data    = 8'($urandom);
      step();
    end
    up_valid = 1'b0; down_ready = 1'b1;
    step(); step(); step();
    chk++; if (sb.size() != 0) $display("FAIL tog_left got %0d want 0", sb.size()); else pass++;
    chk++; if (up_cnt !== down_cnt || up_cnt == 16'd0) $display("FAIL tog_cnt got %0d/%0d want equal nonzero", up_cnt, down_cnt); else pass++;
  endtask

  task automatic test_flush();
    apply_reset();
    up_valid = 1'b1; up_data = 8'h55;
    step();
    up_data = 8'h66;
    step();
    chk++; if (level !== 2'd2) $display("FAIL fl_pre got %0d want 2", level); else pass++;
    flush = 1'b1; up_data = 8'h99;
    step();
    flush = 1'b0; up_valid = 1'b0;
    chk++; if (level !== 2'd0 || down_valid !== 1'b0 || up_ready !== 1'b1) $display("FAIL fl_full got l=%0d v=%0b r=%0b want 0 0 1", level, down_valid, up_ready); else pass++;
    chk++; if (up_cnt !== 16'd2 || down_cnt !== 16'd0) $display("FAIL fl_cnt got %0d/%0d want 2/0", up_cnt, down_cnt); else pass++;
    // Flush at level 1 with a live up beat and a completing down beat.
    up_valid = 1'b1; up_data = 8'h11;
    step();
    flush = 1'b1; up_data = 8'h22; down_ready = 1'b1;
    step();
    flush = 1'b0; up_valid = 1'b0; down_ready = 1'b0;
    chk++; if (level !== 2'd0 || down_valid !== 1'b0) $display("FAIL fl_busy got l=%0d v=%0b want 0 0", level, down_valid); else pass++;
    chk++; if (up_cnt !== 16'd3 || down_cnt !== 16'd1) $display("FAIL fl_busy_cnt got %0d/%0d want 3/1", up_cnt, down_cnt); else pass++;
  endtask

  task automatic test_wrap_reset();
    apply_reset();
    down_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      up_valid = 1'b1; up_data = 8'(8'hC0 + i);
      step();
    end
    up_valid = 1'b0;
    step();
    chk++; if (up_cnt4 !== 4'd1 || down_cnt4 !== 4'd1) $display("FAIL wrap_cnt4 got %0d/%0d want 1/1", up_cnt4, down_cnt4); else pass++;
    chk++; if (up_cnt !== 16'd17) $display("FAIL wrap_cnt16 got %0d want 17", up_cnt); else pass++;
    down_ready = 1'b0; up_valid = 1'b1; up_data = 8'hE5;
    step();
    up_valid = 1'b0;
    chk++; if (level !== 2'd1 || down_data !== 8'hE5) $display("FAIL wrap_pre got l=%0d d=%02h want 1 e5", level, down_data); else pass++;
    #5 rst_n = 1'b0;
    #1;
    chk++; if (down_valid !== 1'b0 || level !== 2'd0 || up_ready !== 1'b1 || down_data !== 8'h00)
      $display("FAIL async_rst got v=%0b l=%0d r=%0b d=%02h want 0 0 1 00", down_valid, level, up_ready, down_data); else pass++;
    chk++; if (up_cnt !== 16'd0 || up_cnt4 !== 4'd0 || down_valid4 !== 1'b0 || level4 !== 2'd0 || up_ready4 !== 1'b1 || down_data4 !== 8'h00)
      $display("FAIL async_rst4 got c=%0d/%0d v=%0b l=%0d want 0/0 0 0", up_cnt, up_cnt4, down_valid4, level4); else pass++;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_toggle();
    test_flush();
    test_wrap_reset();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
